// File: rtl/master_port.sv
// Initiator end of the serial system-bus link: serializes address/write data, deserializes read replies.
// Optional wait-cycle timeout enabled by defining MASTER_PORT_TIMEOUT_EN.
module master_port #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  read_en,
    output logic                  write_en,
    output logic                  master_valid,
    output logic                  master_ready,
    input  logic                  slave_ready,
    input  logic                  slave_valid,
    input  logic                  slave_rx_done,
    input  logic                  slave_tx_done,
    output logic                  tx_address,
    output logic                  tx_data,
    input  logic                  rx_data
);
    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ADDR, S_WDATA, S_WACK, S_RDATA, S_RESP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rbuf, r_rdata;
    logic                  r_write, r_err;
    logic                  w_accept, w_rbit, w_err_set, w_tmo;
    logic [DATA_WIDTH-1:0] w_mask, w_rbuf_nxt;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;
    logic          w_wait;

    // Only consecutive stall cycles count; any progress or state change restarts the count.
    assign w_wait = (r_state == S_REQ   && !slave_ready)   ||
                    (r_state == S_WACK  && !slave_rx_done) ||
                    (r_state == S_RDATA && !slave_valid);
    assign w_tmo  = w_wait && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_tmo <= '0;
        else if (w_state_nxt != r_state || !w_wait)
            r_tmo <= '0;
        else
            r_tmo <= r_tmo + TW'(1);
    end
`else
    assign w_tmo = (TIMEOUT_CYCLES < 0);
`endif

    assign w_mask     = DATA_WIDTH'(1) << r_cnt;
    assign w_rbuf_nxt = (w_rbit && rx_data) ? (r_rbuf | w_mask) : r_rbuf;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rbit      = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE:  if (req_valid) begin
                         w_accept    = 1'b1;
                         w_state_nxt = S_REQ;
                     end
            S_REQ:   if (slave_ready) w_state_nxt = S_ADDR;
            S_ADDR:  if (r_cnt == ADDR_LAST) w_state_nxt = r_write ? S_WDATA : S_RDATA;
            S_WDATA: if (r_cnt == DATA_LAST) w_state_nxt = S_WACK;
            S_WACK:  if (slave_rx_done) w_state_nxt = S_RESP;
            S_RDATA: begin
                w_rbit = slave_valid;
                // tx_done must coincide with the last bit; early or missing flags an error.
                if (slave_valid && r_cnt == DATA_LAST) begin
                    w_state_nxt = S_RESP;
                    w_err_set   = !slave_tx_done;
                end else if (slave_tx_done) begin
                    w_state_nxt = S_RESP;
                    w_err_set   = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_tmo) begin
            w_state_nxt = S_RESP;
            w_err_set   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rbuf  <= '0;
            r_rdata <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if (r_state == S_ADDR || r_state == S_WDATA || w_rbit)
                r_cnt <= r_cnt + CW'(1);
            if (w_accept) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_write <= req_write;
                r_rbuf  <= '0;
            end else begin
                if (r_state == S_ADDR)  r_addr  <= r_addr >> 1;
                if (r_state == S_WDATA) r_wdata <= r_wdata >> 1;
                r_rbuf <= w_rbuf_nxt;
            end
            if (w_state_nxt == S_RESP) begin
                r_err <= w_err_set;
                if (!r_write) r_rdata <= w_rbuf_nxt;
            end
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign resp_valid   = (r_state == S_RESP);
    assign resp_err     = (r_state == S_RESP) && r_err;
    assign resp_rdata   = r_rdata;
    assign master_valid = (r_state == S_REQ) || (r_state == S_ADDR) || (r_state == S_WDATA);
    assign master_ready = (r_state == S_RDATA);
    assign read_en      = !r_write && ((r_state == S_REQ) || (r_state == S_ADDR) || (r_state == S_RDATA));
    assign write_en     = r_write && ((r_state == S_REQ) || (r_state == S_ADDR) ||
                                      (r_state == S_WDATA) || (r_state == S_WACK));
    assign tx_address   = (r_state == S_ADDR) && r_addr[0];
    assign tx_data      = (r_state == S_WDATA) && r_wdata[0];
endmodule

// File: tb/tb_master_port.sv
// Self-checking bench for master_port: acts as bus master and slave, compares against a transaction-level model.
module tb_master_port;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          slave_ready = 1'b0, slave_valid = 1'b0, slave_rx_done = 1'b0;
    logic          slave_tx_done = 1'b0, rx_data = 1'b0;
    logic          req_ready, resp_valid, resp_err, busy, read_en, write_en;
    logic          master_valid, master_ready, tx_address, tx_data;
    logic [DW-1:0] resp_rdata;

    always #5 clk = ~clk;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .read_en(read_en), .write_en(write_en),
        .master_valid(master_valid), .master_ready(master_ready),
        .slave_ready(slave_ready), .slave_valid(slave_valid),
        .slave_rx_done(slave_rx_done), .slave_tx_done(slave_tx_done),
        .tx_address(tx_address), .tx_data(tx_data), .rx_data(rx_data)
    );

    int n_checks = 0;
    int n_errors = 0;
    int rd_stall[DW];
    int o_n, o_extra, o_rr, o_wait, o_ctl;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wd, o_rdata;
    logic          o_err;
    logic [DW-1:0] exp_hold = '0;

    // Transaction-level expectations: resp cycle index counted from the cycle after the accept edge.
    function automatic int exp_lat(bit wr, int rdy, int ack, int done_pos);
        int n = rdy + 1 + AW;
        if (wr) return n + DW + ack + 1;
        for (int i = 0; i < DW; i++) begin
            n += rd_stall[i] + 1;
            if (i == done_pos) break;
        end
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_rd(logic [DW-1:0] rd, int done_pos);
        logic [DW-1:0] m = '0;
        for (int i = 0; i < DW; i++) if (i <= done_pos) m[i] = 1'b1;
        return rd & m;
    endfunction

    // Drives one request and plays the slave; records what the port did.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int rdy, input int ack, input logic [DW-1:0] rd,
                           input int done_pos, input int max_cyc, input bit hold);
        int a0, d0, bi, st;
        bit fin, exp_mv;
        o_n = -1; o_extra = 0; o_rr = 0; o_wait = 0; o_ctl = 0;
        o_addr = '0; o_wd = '0; o_err = 1'b0; o_rdata = '0;
        a0 = rdy + 1; d0 = a0 + AW; bi = 0; st = 0; fin = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        while (!req_ready && o_wait < 50) begin
            @(negedge clk);
            o_wait++;
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        else begin
            req_addr  = AW'($urandom);
            req_wdata = DW'($urandom);
        end
        for (int c = 0; c < max_cyc; c++) begin
            if (c > 0) @(negedge clk);
            if (req_ready) o_rr++;
            if (resp_valid) begin
                o_n = c; o_err = resp_err; o_rdata = resp_rdata;
                if (read_en || write_en || master_valid || master_ready || tx_address || tx_data)
                    o_ctl++;
                break;
            end
            exp_mv = wr ? (c < d0 + DW) : (c < d0);
            if (busy !== 1'b1 || write_en !== wr || read_en !== !wr || master_valid !== exp_mv ||
                master_ready !== (!wr && c >= d0))
                o_ctl++;
            if (c >= a0 && c < a0 + AW) o_addr |= AW'(tx_address) << (c - a0);
            else if (tx_address) o_extra++;
            if (wr && c >= d0 && c < d0 + DW) o_wd |= DW'(tx_data) << (c - d0);
            else if (tx_data) o_extra++;
            slave_ready   = (c >= rdy);
            slave_rx_done = wr && (c == d0 + DW + ack);
            slave_valid = 1'b0; rx_data = 1'b0; slave_tx_done = 1'b0;
            if (!wr && c >= d0 && !fin) begin
                if (c == d0) st = rd_stall[0];
                if (st > 0) st--;
                else begin
                    slave_valid = 1'b1; rx_data = rd[bi]; slave_tx_done = (bi == done_pos);
                    if (bi == done_pos || bi == DW - 1) fin = 1'b1;
                    else begin
                        bi++;
                        st = rd_stall[bi];
                    end
                end
            end
        end
        slave_ready = 1'b0; slave_rx_done = 1'b0; slave_valid = 1'b0;
        rx_data = 1'b0; slave_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        repeat (3) @(negedge clk);
        got = {req_ready, busy, resp_valid, resp_err, read_en, write_en,
               master_valid, master_ready, tx_address, tx_data, |resp_rdata};
        n_checks++;
        if (got !== 11'b100_0000_0000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected %b", got, 11'b100_0000_0000);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset: ready=%b busy=%b expected 1 0", req_ready, busy);
        end
    endtask

    task automatic test_write_directed();
        for (int i = 0; i < DW; i++) rd_stall[i] = 0;
        run_txn(1'b1, 12'hA5C, 8'h3E, 0, 2, '0, DW - 1, 100, 1'b0);
        n_checks++;
        if (o_n !== exp_lat(1'b1, 0, 2, DW - 1)) begin
            n_errors++; $display("FAIL wr_latency: got %0d expected %0d", o_n, exp_lat(1'b1, 0, 2, DW - 1));
        end
        n_checks++;
        if (o_addr !== 12'hA5C) begin n_errors++; $display("FAIL wr_addr_bits: got %h expected a5c", o_addr); end
        n_checks++;
        if (o_wd !== 8'h3E) begin n_errors++; $display("FAIL wr_data_bits: got %h expected 3e", o_wd); end
        n_checks++;
        if (o_err !== 1'b0 || o_extra !== 0 || o_rr !== 0 || o_ctl !== 0) begin
            n_errors++;
            $display("FAIL wr_protocol: err=%b stray=%0d ready=%0d ctl=%0d expected 0 0 0 0", o_err, o_extra, o_rr, o_ctl);
        end
    endtask

    task automatic test_read_directed();
        for (int i = 0; i < DW; i++) rd_stall[i] = 0;
        rd_stall[2] = 1; rd_stall[5] = 1;
        run_txn(1'b0, 12'h001, '0, 1, 0, 8'hC3, DW - 1, 100, 1'b0);
        exp_hold = 8'hC3;
        n_checks++;
        if (o_n !== exp_lat(1'b0, 1, 0, DW - 1)) begin
            n_errors++; $display("FAIL rd_latency: got %0d expected %0d", o_n, exp_lat(1'b0, 1, 0, DW - 1));
        end
        n_checks++;
        if (o_rdata !== 8'hC3 || o_err !== 1'b0) begin
            n_errors++; $display("FAIL rd_data: got %h err=%b expected c3 err=0", o_rdata, o_err);
        end
        n_checks++;
        if (o_addr !== 12'h001 || o_extra !== 0 || o_ctl !== 0) begin
            n_errors++; $display("FAIL rd_protocol: addr=%h stray=%0d ctl=%0d expected 001 0 0", o_addr, o_extra, o_ctl);
        end
    endtask

    task automatic test_read_early_done();
        logic [DW-1:0] rd;
        for (int i = 0; i < DW; i++) rd_stall[i] = 0;
        rd = 8'hFF ^ DW'($urandom_range(0, 7));
        run_txn(1'b0, AW'($urandom), '0, 0, 0, rd, 3, 100, 1'b0);
        exp_hold = exp_rd(rd, 3);
        n_checks++;
        if (o_n !== exp_lat(1'b0, 0, 0, 3)) begin
            n_errors++; $display("FAIL early_latency: got %0d expected %0d", o_n, exp_lat(1'b0, 0, 0, 3));
        end
        n_checks++;
        if (o_err !== 1'b1 || o_rdata !== exp_hold) begin
            n_errors++; $display("FAIL early_resp: got %h err=%b expected %h err=1", o_rdata, o_err, exp_hold);
        end
    endtask

    task automatic test_reset_mid_addr();
        int seen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = AW'($urandom); req_wdata = DW'($urandom);
        slave_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({req_ready, busy, master_valid, write_en, tx_address, tx_data, resp_rdata} !== {6'b100000, DW'(0)}) begin
            n_errors++;
            $display("FAIL reset_mid: ready=%b busy=%b mv=%b we=%b txa=%b txd=%b rdata=%h expected 1 0 0 0 0 0 00",
                     req_ready, busy, master_valid, write_en, tx_address, tx_data, resp_rdata);
        end
        exp_hold = '0;
        @(negedge clk);
        reset = 1'b0; slave_ready = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_errors++; $display("FAIL reset_discard: got %0d active cycles expected 0", seen); end
        a = AW'($urandom); d = DW'($urandom);
        for (int i = 0; i < DW; i++) rd_stall[i] = 0;
        run_txn(1'b1, a, d, 2, 1, '0, DW - 1, 100, 1'b0);
        n_checks++;
        if (o_n !== exp_lat(1'b1, 2, 1, DW - 1) || o_addr !== a || o_wd !== d || o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL post_reset_write: lat=%0d addr=%h data=%h err=%b expected %0d %h %h 0",
                     o_n, o_addr, o_wd, o_err, exp_lat(1'b1, 2, 1, DW - 1), a, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] d1, d2;
        a1 = AW'($urandom); a2 = AW'($urandom); d1 = DW'($urandom); d2 = DW'($urandom);
        for (int i = 0; i < DW; i++) rd_stall[i] = 0;
        run_txn(1'b1, a1, d1, 0, 0, '0, DW - 1, 100, 1'b1);
        n_checks++;
        if (o_rr !== 0 || o_addr !== a1 || o_wd !== d1 || o_n !== exp_lat(1'b1, 0, 0, DW - 1)) begin
            n_errors++;
            $display("FAIL b2b_first: ready=%0d addr=%h data=%h lat=%0d expected 0 %h %h %0d",
                     o_rr, o_addr, o_wd, o_n, a1, d1, exp_lat(1'b1, 0, 0, DW - 1));
        end
        run_txn(1'b1, a2, d2, 0, 0, '0, DW - 1, 100, 1'b0);
        n_checks++;
        if (o_wait !== 0) begin n_errors++; $display("FAIL b2b_accept: got %0d wait cycles expected 0", o_wait); end
        n_checks++;
        if (o_addr !== a2 || o_wd !== d2 || o_n !== exp_lat(1'b1, 0, 0, DW - 1)) begin
            n_errors++;
            $display("FAIL b2b_second: addr=%h data=%h lat=%0d expected %h %h %0d",
                     o_addr, o_wd, o_n, a2, d2, exp_lat(1'b1, 0, 0, DW - 1));
        end
    endtask

    task automatic test_timeout();
        run_txn(1'b1, AW'($urandom), DW'($urandom), 1000, 0, '0, DW - 1, 40, 1'b0);
`ifdef MASTER_PORT_TIMEOUT_EN
        n_checks++;
        if (o_n !== 16 || o_err !== 1'b1) begin
            n_errors++; $display("FAIL timeout_resp: lat=%0d err=%b expected 16 1", o_n, o_err);
        end
`else
        n_checks++;
        if (o_n !== -1 || busy !== 1'b1 || master_valid !== 1'b1 || o_ctl !== 0) begin
            n_errors++;
            $display("FAIL wait_forever: resp_at=%0d busy=%b mv=%b ctl=%0d expected -1 1 1 0", o_n, busy, master_valid, o_ctl);
        end
`endif
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        exp_hold = '0;
    endtask

    task automatic test_random();
        bit wr;
        int rdy, ack, dp, lat;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd;
        for (int t = 0; t < 12; t++) begin
            wr = 1'($urandom); a = AW'($urandom); d = DW'($urandom); rd = DW'($urandom);
            rdy = $urandom_range(0, 3); ack = $urandom_range(0, 3);
            dp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DW) : DW - 1;
            for (int i = 0; i < DW; i++) rd_stall[i] = $urandom_range(0, 2);
            lat = exp_lat(wr, rdy, ack, dp);
            run_txn(wr, a, d, rdy, ack, rd, dp, 200, 1'b0);
            if (!wr) exp_hold = exp_rd(rd, dp);
            n_checks++;
            if (o_n !== lat || o_addr !== a || o_extra !== 0 || o_ctl !== 0 || o_rr !== 0) begin
                n_errors++;
                $display("FAIL rnd%0d_link: lat=%0d addr=%h stray=%0d ctl=%0d ready=%0d expected %0d %h 0 0 0",
                         t, o_n, o_addr, o_extra, o_ctl, o_rr, lat, a);
            end
            n_checks++;
            if (o_rdata !== exp_hold || o_err !== (!wr && dp != DW - 1) || (wr && o_wd !== d)) begin
                n_errors++;
                $display("FAIL rnd%0d_resp: wr=%b rdata=%h err=%b wdata=%h expected rdata=%h err=%b wdata=%h",
                         t, wr, o_rdata, o_err, o_wd, exp_hold, (!wr && dp != DW - 1), d);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_directed();
        test_read_directed();
        test_read_early_done();
        test_reset_mid_addr();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
